mul_add_arbiter: RTL and testbench



---
 rtl/mul_add_arbiter.sv | 96 +++++++++
 tb/tb_mul_add_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_arbiter.sv
// Round-robin arbiter sharing one signed multiply-add unit among NREQ requesters.
// One registered result slot with valid/ready; results are tagged with the requester index.
module mul_add_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_c,
    input  logic [NREQ*W-1:0] req_d,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IW-1:0]     resp_id,
    output logic [2*W-1:0]    resp_data,
    output logic [15:0]       op_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic                found;
    logic [IW-1:0]       gidx;
    logic                slot_free;
    logic                accept;
    int                  j;

    logic signed [W-1:0] a_arr [NREQ];
    logic signed [W-1:0] b_arr [NREQ];
    logic        [W-1:0] c_arr [NREQ];
    logic        [W-1:0] d_arr [NREQ];

    // The 2W-bit context makes the signed product exact; the add wraps mod 2^(2W).
    function automatic logic [2*W-1:0] mul_add(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic        [W-1:0] c,
        input logic        [W-1:0] d
    );
        logic signed [2*W-1:0] prod;
        prod = a * b;
        return prod + {c, d};
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
        assign c_arr[i] = req_c[i*W +: W];
        assign d_arr[i] = req_d[i*W +: W];
    end

    // Grant: first valid requester scanning from ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[IW'(j)]) begin
                found = 1'b1;
                gidx  = IW'(j);
            end
        end
    end

    assign slot_free  = (state == EMPTY) || resp_ready;
    assign accept     = !rst && slot_free && found;
    assign req_ready  = accept ? (NREQ'(1) << gidx) : '0;
    assign resp_valid = (state == FULL);

    // Result stage: one registered slot holding the product-sum and its tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            ptr       <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            op_count  <= '0;
        end else if (accept) begin
            state     <= FULL;
            resp_id   <= gidx;
            resp_data <= mul_add(a_arr[gidx], b_arr[gidx], c_arr[gidx], d_arr[gidx]);
            ptr       <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            op_count  <= op_count + 16'd1;
        end else if (state == FULL && resp_ready) begin
            state     <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mul_add_arbiter.sv
// Bench for mul_add_arbiter: directed scenarios plus random traffic checked
// against a behavioural model of the arbitration and arithmetic rules.
module tb_mul_add_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b, req_c, req_d;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [2*W-1:0]    resp_data;
    logic [15:0]       op_count;

    mul_add_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester-side operand store
    logic         vld [NREQ];
    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    logic [W-1:0] op_c [NREQ];
    logic [W-1:0] op_d [NREQ];

    // Reference model state
    bit           m_full;
    int           m_ptr;
    int           m_id;
    logic [2*W-1:0] m_data;
    logic [15:0]  m_cnt;

    logic [2*W-1:0] saved_data;
    logic [IW-1:0]  saved_id;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] c, input logic [W-1:0] d);
        int p, s;
        p = $signed(a) * $signed(b);
        s = p + int'(c) * (1 << W) + int'(d);
        return s[2*W-1:0];
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic pack_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = vld[i];
            req_a[i*W +: W]    = op_a[i];
            req_b[i*W +: W]    = op_b[i];
            req_c[i*W +: W]    = op_c[i];
            req_d[i*W +: W]    = op_d[i];
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
        vld[i] = 1'b1; op_a[i] = a; op_b[i] = b; op_c[i] = c; op_d[i] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance both.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_ready;
        bit acc;
        pack_inputs();
        g = model_grant();
        acc = !rst && (g >= 0) && (!m_full || resp_ready);
        exp_ready = acc ? (NREQ'(1) << g) : '0;
        #1;
        check_val("req_ready", req_ready, exp_ready);
        check_val("resp_valid", resp_valid, m_full);
        check_val("resp_id", resp_id, m_id);
        check_val("resp_data", resp_data, m_data);
        check_val("op_count", op_count, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_ptr = 0; m_id = 0; m_data = '0; m_cnt = '0;
        end else if (acc) begin
            m_full = 1;
            m_id   = g;
            m_data = ref_mac(op_a[g], op_b[g], op_c[g], op_d[g]);
            m_ptr  = (g + 1) % NREQ;
            m_cnt  = m_cnt + 16'd1;
            vld[g] = 1'b0;
        end else if (m_full && resp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        m_full = 0; m_ptr = 0; m_id = 0; m_data = '0; m_cnt = '0;
        rst = 1'b1;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        pack_inputs();
        @(posedge clk);
        #1;
        // Reset state with all requests pending: nothing accepted
        step();
        step();
        check_val("rst_valid", resp_valid, 0);
        check_val("rst_count", op_count, 0);
        rst = 1'b0;
        clear_all();

        // Single op from requester 1: -3*5 + 16 = 1
        set_req(1, 4'hD, 4'h5, 4'h1, 4'h0);
        pack_inputs();
        #1 check_val("single_ready", req_ready, 4'b0010);
        step();
        check_val("single_valid", resp_valid, 1);
        check_val("single_id", resp_id, 1);
        check_val("single_data", resp_data, 8'h01);
        check_val("single_count", op_count, 1);

        // Wrap: 64 + 255 mod 256; pointer 2 skips to requester 0
        resp_ready = 1'b1;
        set_req(0, 4'h8, 4'h8, 4'hF, 4'hF);
        pack_inputs();
        #1 check_val("skip_ready", req_ready, 4'b0001);
        step();
        check_val("wrap_data", resp_data, 8'h3F);
        check_val("wrap_id", resp_id, 0);
        // Pointer now 1: requester 1 wins over 0
        set_req(0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        set_req(1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        step();
        check_val("ptr_after_skip", resp_id, 1);
        clear_all();

        // Round robin with all requesters busy
        do_reset();
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            pack_inputs();
            #1 check_val("rr_grant", req_ready, NREQ'(1) << (k % NREQ));
            step();
        end
        check_val("rr_count", op_count, 6);
        clear_all();

        // Backpressure holds the result and blocks all grants
        do_reset();
        set_req(0, 4'h3, 4'h2, 4'h0, 4'h1);
        step();
        saved_data = resp_data;
        saved_id   = resp_id;
        resp_ready = 1'b0;
        set_req(1, 4'h7, 4'h7, 4'h0, 4'h0);
        set_req(2, 4'h9, 4'h2, 4'h1, 4'h1);
        for (int k = 0; k < 3; k++) begin
            pack_inputs();
            #1 check_val("bp_ready", req_ready, 0);
            step();
            check_val("bp_data", resp_data, saved_data);
            check_val("bp_id", resp_id, saved_id);
        end
        resp_ready = 1'b1;
        pack_inputs();
        #1 check_val("bp_release", req_ready, 4'b0010);
        step();
        check_val("bp_new_data", resp_data, 8'h31);

        // Reset while FULL with every requester pending
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        rst = 1'b1;
        pack_inputs();
        #1 check_val("midrst_ready", req_ready, 0);
        step();
        check_val("midrst_valid", resp_valid, 0);
        check_val("midrst_count", op_count, 0);
        rst = 1'b0;
        pack_inputs();
        #1 check_val("post_rst_grant", req_ready, 4'b0001);
        step();

        // Random traffic obeying the hold-until-ready rule
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!vld[i] && $urandom_range(0, 2) == 0)
                    set_req(i, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
